// File: rtl/hc595_if.sv
// Bus bundle for hc595_sipo: serial input, control strobes and status outputs.
// The tri-stated parallel output Q stays a plain port on the module.
interface hc595_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic          Ser;
    logic          Shift_En;
    logic          Latch;
    logic          Auto;
    logic          Clr;
    logic          OE_N;
    logic          Qs;
    logic          Done;
    logic [CW-1:0] Cnt;

    modport master (
        output Ser, Shift_En, Latch, Auto, Clr, OE_N,
        input  Qs, Done, Cnt
    );

    modport slave (
        input  Ser, Shift_En, Latch, Auto, Clr, OE_N,
        output Qs, Done, Cnt
    );
endinterface

// File: rtl/hc595_sipo.sv
// 74HC595-style serial-in / parallel-out register with storage latch,
// output enable, frame bit counter, optional auto-latch and frame-done pulse.
// Legal WIDTH range is 2..16.
module hc595_sipo #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             R,
    hc595_if.slave           bus,
    output wire [WIDTH-1:0]  Q
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] stor;
    logic [CW-1:0]    cnt;
    logic             done;
    logic [WIDTH-1:0] shifted;
    logic             do_shift;
    logic             frame_end;

    // Post-shift word and frame-completion qualifiers shared by all registers
    always_comb begin
        shifted   = {sr[WIDTH-2:0], bus.Ser};
        do_shift  = bus.Shift_En & ~bus.Clr;
        frame_end = do_shift & (cnt == CW'(WIDTH - 1));
    end

    // Shift register and bit counter; clear beats shift
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            sr  <= '0;
            cnt <= '0;
        end else if (bus.Clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (do_shift) begin
            sr  <= shifted;
            cnt <= frame_end ? '0 : cnt + CW'(1);
        end
    end

    // Storage register: auto-latch of the completed word wins over a manual latch of the pre-shift word
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            stor <= '0;
        end else if (frame_end && bus.Auto) begin
            stor <= shifted;
        end else if (bus.Latch) begin
            stor <= sr;
        end
    end

    // Frame-done flag, high for the single cycle after the completing edge
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            done <= 1'b0;
        end else begin
            done <= frame_end;
        end
    end

    assign Q        = bus.OE_N ? {WIDTH{1'bz}} : stor;
    assign bus.Qs   = sr[WIDTH-1];
    assign bus.Done = done;
    assign bus.Cnt  = cnt;
endmodule

// File: tb/tb_hc595_sipo.sv
// Scoreboard bench for hc595_sipo: directed test-plan sequences followed by
// random traffic, checked against a bit-queue reference model.
module tb_hc595_sipo;
    localparam int W  = 8;
    localparam int CW = 3;

    typedef struct {
        logic [W-1:0]  stor;
        logic          oe_n;
        logic          qs;
        logic          done;
        logic [CW-1:0] cnt;
    } exp_t;

    logic Clk = 1'b0;
    logic R   = 1'b0;
    wire [W-1:0] Q;

    hc595_if #(.WIDTH(W)) bus ();

    hc595_sipo #(.WIDTH(W)) dut (
        .Clk (Clk),
        .R   (R),
        .bus (bus.slave),
        .Q   (Q)
    );

    // Free-running clock
    always #5 Clk = ~Clk;

    // Reference model: bits shifted since the last clear/reset, position in frame, latched word
    bit           m_hist[$];
    int           m_pos;
    logic [W-1:0] m_stor;

    exp_t exp_q[$];
    event mid_check;
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [W-1:0] m_sr_value();
        logic [W-1:0] value;
        value = '0;
        foreach (m_hist[i]) value = value * 2 + W'(m_hist[i]);
        return value;
    endfunction

    task automatic push_expect(input logic oe_n, input logic done);
        exp_t         e;
        logic [W-1:0] srv;
        srv    = m_sr_value();
        e.stor = m_stor;
        e.oe_n = oe_n;
        e.qs   = srv[W-1];
        e.done = done;
        e.cnt  = CW'(m_pos);
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        if (!e.oe_n) begin
            checks++;
            if (Q !== e.stor) begin
                fails++;
                $display("[TB] FAIL Q: got %h, expected %h", Q, e.stor);
            end
        end else if (e.stor != '0) begin
            checks++;
            if (Q === e.stor) begin
                fails++;
                $display("[TB] FAIL Q_disabled: got %h, expected high-Z not %h", Q, e.stor);
            end
        end
        checks++;
        if (bus.Qs !== e.qs) begin
            fails++;
            $display("[TB] FAIL Qs: got %b, expected %b", bus.Qs, e.qs);
        end
        checks++;
        if (bus.Done !== e.done) begin
            fails++;
            $display("[TB] FAIL Done: got %b, expected %b", bus.Done, e.done);
        end
        checks++;
        if (bus.Cnt !== e.cnt) begin
            fails++;
            $display("[TB] FAIL Cnt: got %0d, expected %0d", bus.Cnt, e.cnt);
        end
    endtask

    // Monitor: compares the oldest expectation once per negedge, or on a mid-cycle request
    initial begin
        forever begin
            @(negedge Clk or mid_check);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    // One clock edge of stimulus; the model advances and its result is queued
    task automatic applyStimulus(input logic ser, input logic shift_en, input logic latch,
                                 input logic auto_ld, input logic clr, input logic oe_n);
        logic [W-1:0] pre;
        logic         done;
        @(negedge Clk);
        #2;
        bus.Ser      = ser;
        bus.Shift_En = shift_en;
        bus.Latch    = latch;
        bus.Auto     = auto_ld;
        bus.Clr      = clr;
        bus.OE_N     = oe_n;
        pre  = m_sr_value();
        done = 1'b0;
        @(posedge Clk);
        if (clr) begin
            m_hist.delete();
            m_pos = 0;
            if (latch) m_stor = pre;
        end else if (shift_en) begin
            m_hist.push_back(ser);
            if (m_hist.size() > W) void'(m_hist.pop_front());
            m_pos++;
            if (m_pos == W) begin
                m_pos = 0;
                done  = 1'b1;
            end
            if (done && auto_ld) m_stor = m_sr_value();
            else if (latch)      m_stor = pre;
        end else if (latch) begin
            m_stor = pre;
        end
        push_expect(oe_n, done);
    endtask

    // Reset asserted between edges; outputs are checked before the next edge
    task automatic reset_mid();
        @(negedge Clk);
        #2;
        R = 1'b0;
        m_hist.delete();
        m_pos  = 0;
        m_stor = '0;
        push_expect(bus.OE_N, 1'b0);
        ->mid_check;
        bus.Shift_En = 1'b0;
        bus.Latch    = 1'b0;
        bus.Clr      = 1'b0;
        @(posedge Clk);
        #1;
        R = 1'b1;
    endtask

    task automatic shift_byte(input logic [7:0] val, input logic auto_ld, input logic latch_last);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(val[i], 1'b1, latch_last && (i == 0), auto_ld, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input logic oe_n);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, oe_n);
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus: directed test-plan sequences then random traffic
    initial begin
        bus.Ser = 0; bus.Shift_En = 0; bus.Latch = 0;
        bus.Auto = 0; bus.Clr = 0; bus.OE_N = 0;
        m_pos = 0;
        m_stor = '0;
        #1;
        push_expect(1'b0, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        R = 1'b1;

        // Asynchronous reset mid-clock after some state is built up
        shift_byte(8'hC3, 1'b1, 1'b0);
        reset_mid();

        // Auto latch, two frames back to back then idle
        shift_byte(8'hA5, 1'b1, 1'b0);
        idle(1'b0);
        shift_byte(8'h3C, 1'b1, 1'b0);
        idle(1'b0);

        // Manual latch
        reset_mid();
        shift_byte(8'hF0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Latch collision on the completing edge
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        shift_byte(8'h81, 1'b1, 1'b1);
        idle(1'b0);

        // Mid-frame abort by clear, then by reset
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        shift_byte(8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        reset_mid();
        shift_byte(8'h5A, 1'b1, 1'b0);

        // Output enable toggling
        shift_byte(8'hA5, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if (n % 97 == 50) begin
                reset_mid();
            end else begin
                applyStimulus(1'($urandom_range(0, 1)),
                              $urandom_range(0, 9) < 8,
                              $urandom_range(0, 9) == 0,
                              $urandom_range(0, 3) != 0,
                              $urandom_range(0, 29) == 0,
                              $urandom_range(0, 9) == 0);
            end
        end

        @(negedge Clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/hc595_sipo.md
# hc595_sipo

Single-clock serial-in / parallel-out shift register with a separate storage register and output enable, modelled on the 74HC595. It sits directly downstream of the dual D flip-flop stage: that stage's registered `Q` output drives `Ser`, and this block assembles those bits into a parallel word for the display/LED side of the design. A bit counter supports an optional automatic latch after every `WIDTH` bits and raises a one-cycle frame-done flag.

## Interface
- `WIDTH`, default 8: shift/storage register width; legal range is 2 to 16.
- `Clk`, input, 1: clock; all state updates on its rising edge.
- `R`, input, 1: asynchronous, active-low reset.
- `Ser`, input, 1: serial data in, sampled when `Shift_En`=1.
- `Shift_En`, input, 1: shift enable.
- `Latch`, input, 1: manual storage-register load strobe, sampled at the edge.
- `Auto`, input, 1: when 1, the storage register loads automatically when a frame completes.
- `Clr`, input, 1: synchronous, active-high clear of the shift register and bit counter. It does not affect the storage register.
- `OE_N`, input, 1: active-low output enable for `Q`.
- `Q`, output, `WIDTH`: parallel output. Equals `stor` when `OE_N`=0, and is high-impedance when `OE_N`=1.
- `Qs`, output, 1: serial cascade output, equal to `sr[WIDTH-1]`.
- `Done`, output, 1: one-cycle pulse marking frame completion.
- `Cnt`, output, `$clog2(WIDTH)`: number of bits shifted in the current frame.

## Operation
- **Internal state:** `sr` (shift register), `stor` (storage register), `Cnt`, `Done`.
- **Reset** (`R`=0, asynchronous):
  - `sr`, `stor`, `Cnt` and `Done` all clear to 0.
  - `Qs`=0.
  - `Q`=0 if `OE_N`=0, high-impedance otherwise.
  - Reset overrides every other input.
- **Priority per edge:** `Clr`, then shift, then latch.
- **`Clr`=1:**
  - `sr` and `Cnt` clear to 0; `Done` is 0 on the next cycle.
  - `Shift_En` is ignored.
  - `Latch`=1 in the same cycle still loads `stor` with the pre-clear `sr`.
- **Shift** (`Shift_En`=1, `Clr`=0):
  - `sr <= {sr[WIDTH-2:0], Ser}`, so the first bit shifted ends up as the MSB.
  - `Cnt` increments and wraps from `WIDTH-1` to 0.
- **Frame complete:** a shift edge where `Cnt`==`WIDTH-1`.
  - `Done` is 1 in the following cycle only.
  - If `Auto`=1, `stor` loads the post-shift word `{sr[WIDTH-2:0], Ser}` on that same edge.
- **Manual latch** (`Latch`=1): `stor <= sr`, using the pre-shift value.
  - With a simultaneous shift, storage is one bit behind the shift register, matching HC595 behaviour with tied clocks.
  - If an auto-latch fires on the same edge, the auto-latch wins and `stor` takes the post-shift word.
- **`Shift_En`=0:** `sr` and `Cnt` hold; `Done` deasserts.
- **`OE_N`:** purely combinational on `Q`. It never changes `stor`.

## Timing
- **Shift latency:** a bit sampled on `Ser` at edge k appears at `sr[0]` after edge k. It appears on `Qs` after `WIDTH` shift edges, i.e. bit k of the frame emerges while frame k+1 is being shifted in.
- **`Q` update:** `Q` reflects the new `stor` immediately after the loading edge, with zero cycles of added latency.
- **`Done`:** registered, asserted for exactly one cycle after the completing edge. With back-to-back frames, `Done` pulses every `WIDTH` shift cycles.
- **Reset mid-frame:** partial frame discarded, `Cnt`=0. The next shifted bit is bit 0 of a new frame.
- **`Clr` mid-frame:** same as reset for `sr` and `Cnt`, but `stor` (and therefore `Q`) is preserved.
- **`Auto` toggled mid-frame:** sampled only on the completing edge.
- **No handshake:** the upstream stage must hold `Ser` stable around the `Clk` edge. Same-clock registered drive from the flip-flop stage satisfies this.

## Test plan
1. **Reset:** assert `R`=0 for 2 cycles with `OE_N`=0 → `Q`=0x00, `Qs`=0, `Cnt`=0, `Done`=0. Also assert `R`=0 mid-clock → outputs clear without waiting for an edge.
2. **Auto latch:** `Auto`=1, `WIDTH`=8; shift 1,0,1,0,0,1,0,1 on consecutive edges → `Q`=0xA5 right after the 8th edge, `Done`=1 for exactly one cycle, `Cnt`=0. A further 8 bits of 0x3C → `Q`=0x3C, and `Qs` replays 1,0,1,0,0,1,0,1 during that frame.
3. **Manual latch:** `Auto`=0; shift 0xF0 → `Q` stays 0x00. `Latch`=1 alone → `Q`=0xF0. `Latch`=1 together with a shift of `Ser`=1 → `Q`=0xF0 (pre-shift value) and `sr`=0xE1.
4. **Latch collision:** `Auto`=1 and `Latch`=1 on the 8th shift edge of 0x81 → `Q`=0x81, not the pre-shift 0x40 or older.
5. **Mid-frame abort:** shift 3 bits, pulse `Clr` → `Cnt`=0, `sr`=0, `Q` unchanged. Shift 3 bits, pulse `R` → `stor`=0. In both cases a following 8-bit 0x5A frame latches 0x5A.
6. **Output enable:** `stor`=0xA5, toggle `OE_N` 0→1→0 → `Q`=0xA5, then Z on all bits, then 0xA5. `stor`, `Cnt` and `Done` are unaffected throughout.
